// File: rtl/priority_decoder_seq.sv
// priority_decoder_seq
// Decodes a 3-bit index into an MSB-first one-hot byte. Each accepted pattern
// is held on y for HOLD_CYCLES cycles. A new request is taken on the last hold
// cycle, so patterns can stream back-to-back. An abort clears the output at
// once.

module priority_decoder_seq #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] code,
  input  logic       abort,
  output logic [7:0] y,
  output logic       out_valid,
  output logic       busy
);

  localparam int            CW   = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cntNext;
  logic [7:0]    r_y;
  logic [7:0]    w_yNext;
  logic [7:0]    w_decoded;
  logic          w_lastCycle;
  logic          w_accept;

  // A request can only be taken when idle or on the final cycle of a hold.
  // This keeps a pattern from being replaced part-way through its hold.
  assign w_lastCycle = (r_cnt == '0);
  assign in_ready    = (r_state == IDLE) || w_lastCycle;
  assign w_accept    = in_valid && in_ready && !abort;

  assign y         = r_y;
  assign out_valid = (r_state == HOLD);
  assign busy      = (r_state == HOLD);

  // MSB-first one-hot decode: code 0 lights bit 7, code 7 lights bit 0.
  always_comb begin
    w_decoded = 8'h00;
    case (code)
      3'd0:    w_decoded = 8'b1000_0000;
      3'd1:    w_decoded = 8'b0100_0000;
      3'd2:    w_decoded = 8'b0010_0000;
      3'd3:    w_decoded = 8'b0001_0000;
      3'd4:    w_decoded = 8'b0000_1000;
      3'd5:    w_decoded = 8'b0000_0100;
      3'd6:    w_decoded = 8'b0000_0010;
      default: w_decoded = 8'b0000_0001;
    endcase
  end

  // Next-state, counter and pattern selection.
  // Abort overrides everything except reset.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_yNext     = r_y;
    if (abort) begin
      w_stateNext = IDLE;
      w_cntNext   = '0;
      w_yNext     = 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          w_yNext   = 8'h00;
          w_cntNext = '0;
          if (w_accept) begin
            w_stateNext = HOLD;
            w_cntNext   = LOAD;
            w_yNext     = w_decoded;
          end
        end
        HOLD: begin
          if (!w_lastCycle) begin
            w_cntNext = r_cnt - ONE;
          end else if (w_accept) begin
            w_cntNext = LOAD;
            w_yNext   = w_decoded;
          end else begin
            w_stateNext = IDLE;
            w_yNext     = 8'h00;
          end
        end
        default: begin
          w_stateNext = IDLE;
          w_cntNext   = '0;
          w_yNext     = 8'h00;
        end
      endcase
    end
  end

  // State, counter and output pattern registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_y     <= 8'h00;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_y     <= w_yNext;
    end
  end

endmodule

// File: tb/tb_priority_decoder_seq.sv
// Testbench for priority_decoder_seq.
// The stimulus process queues the patterns it expects. The monitors pop one
// entry for every cycle that out_valid is high.

module tb_priority_decoder_seq;

  logic       clk = 1'b0;
  logic       rstA, inValidA, inReadyA, abortA, outValidA, busyA;
  logic [2:0] codeA;
  logic [7:0] yA;
  logic       rstB, inValidB, inReadyB, abortB, outValidB, busyB;
  logic [2:0] codeB;
  logic [7:0] yB;

  int         nVectors     = 0;
  int         nMiscompares = 0;
  logic       monEn        = 1'b0;
  logic [7:0] qA[$];
  logic [7:0] qB[$];
  logic [7:0] expTab [8] = '{8'h80, 8'h40, 8'h20, 8'h10,
                             8'h08, 8'h04, 8'h02, 8'h01};

  priority_decoder_seq #(.HOLD_CYCLES(4)) dutA (
    .clk(clk), .rst(rstA), .in_valid(inValidA), .in_ready(inReadyA),
    .code(codeA), .abort(abortA), .y(yA), .out_valid(outValidA), .busy(busyA)
  );

  priority_decoder_seq #(.HOLD_CYCLES(1)) dutB (
    .clk(clk), .rst(rstB), .in_valid(inValidB), .in_ready(inReadyB),
    .code(codeB), .abort(abortB), .y(yB), .out_valid(outValidB), .busy(busyB)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue one pattern that should appear on y for n consecutive cycles.
  task automatic pushA(input logic [7:0] pat, input int n);
    for (int i = 0; i < n; i++) qA.push_back(pat);
  endtask

  // Drive one cycle into the HOLD_CYCLES=4 instance.
  // The task checks in_ready, then returns just after the next rising edge.
  task automatic applyStimulus(input logic v, input logic [2:0] c,
                               input logic ab, input logic r,
                               input logic expReady);
    inValidA = v;
    codeA    = c;
    abortA   = ab;
    rstA     = r;
    #2;
    checkOutput("A in_ready", inReadyA, expReady);
    @(posedge clk);
    #1;
  endtask

  // Monitor for the HOLD_CYCLES=4 instance.
  // Each valid cycle must match the next queued pattern.
  always @(negedge clk) begin
    if (monEn) begin
      checkOutput("A onehot", ($countones(yA) <= 1), 1);
      checkOutput("A busy", busyA, outValidA);
      if (outValidA === 1'b1) begin
        if (qA.size() == 0) checkOutput("A spurious valid", outValidA, 0);
        else checkOutput("A y", yA, qA.pop_front());
      end else begin
        checkOutput("A idle out_valid", outValidA, 0);
        checkOutput("A idle y", yA, 0);
      end
    end
  end

  // Monitor for the HOLD_CYCLES=1 instance.
  always @(negedge clk) begin
    if (monEn) begin
      checkOutput("B onehot", ($countones(yB) <= 1), 1);
      if (outValidB === 1'b1) begin
        if (qB.size() == 0) checkOutput("B spurious valid", outValidB, 0);
        else checkOutput("B y", yB, qB.pop_front());
      end else begin
        checkOutput("B idle out_valid", outValidB, 0);
        checkOutput("B idle y", yB, 0);
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    rstA = 1'b1; inValidA = 1'b0; codeA = 3'd0; abortA = 1'b0;
    rstB = 1'b1; inValidB = 1'b0; codeB = 3'd0; abortB = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    monEn = 1'b1;

    // Reset state
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("reset y", yA, 0);
    checkOutput("reset out_valid", outValidA, 0);
    checkOutput("reset busy", busyA, 0);
    rstB = 1'b0;

    // Single request for code 010.
    // While the block is not ready, in_valid is high with a junk code.
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b0, 1'b1);
    pushA(8'h20, 4);
    repeat (3) applyStimulus(1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("single end out_valid", outValidA, 0);

    // Back-to-back requests: code 000, then code 111.
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 1'b1);
    pushA(8'h80, 4);
    repeat (3) applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b111, 1'b0, 1'b0, 1'b1);
    pushA(8'h01, 4);
    repeat (3) applyStimulus(1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

    // Abort during a hold: the pattern is visible for cycles 1-2 only.
    applyStimulus(1'b1, 3'b101, 1'b0, 1'b0, 1'b1);
    pushA(8'h04, 2);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("abort y", yA, 0);
    checkOutput("abort out_valid", outValidA, 0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

    // Abort together with in_valid while idle must not capture the request.
    applyStimulus(1'b1, 3'b011, 1'b1, 1'b0, 1'b1);
    checkOutput("abort idle out_valid", outValidA, 0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

    // Reset mid-hold; the request presented with rst is dropped.
    applyStimulus(1'b1, 3'b110, 1'b0, 1'b0, 1'b1);
    pushA(8'h02, 2);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b001, 1'b0, 1'b1, 1'b0);
    checkOutput("rst mid-hold y", yA, 0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst after out_valid", outValidA, 0);

    // Full code sweep, streamed back-to-back.
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 3'(c), 1'b0, 1'b0, 1'b1);
      pushA(expTab[c], 4);
      repeat (3) applyStimulus(1'b1, 3'(c), 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

    // HOLD_CYCLES=1: one code per cycle, and in_ready stays high.
    for (int c = 0; c < 8; c++) begin
      inValidB = 1'b1;
      codeB    = 3'(c);
      qB.push_back(expTab[c]);
      #2;
      checkOutput("B in_ready", inReadyB, 1);
      @(posedge clk);
      #1;
    end
    inValidB = 1'b0;
    #2;
    checkOutput("B in_ready idle", inReadyB, 1);
    repeat (3) @(posedge clk);
    #1;

    checkOutput("A queue drained", qA.size(), 0);
    checkOutput("B queue drained", qB.size(), 0);
    monEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
